// File: rtl/shift_si_po_cfg.sv
// Serial-in / parallel-out configuration register with frame-length checking
// and serial readback of the committed setting.
module shift_si_po_cfg #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] DEFAULT   = '0,
    parameter bit               SHIFT_DIR = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Si,
    output logic             So,
    output logic [WIDTH-1:0] Po,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam int unsigned     CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_SAT  = CW'(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic [WIDTH-1:0] sh_shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Shadow register advanced by one bit in the configured direction.
    always_comb begin
        if (SHIFT_DIR == 1'b0) begin
            sh_shifted = {sh_q[WIDTH-2:0], Si};
        end else begin
            sh_shifted = {Si, sh_q[WIDTH-1:1]};
        end
    end

    // Readback tap is the bit about to leave the shadow register.
    always_comb begin
        if (SHIFT_DIR == 1'b0) begin
            So = sh_q[WIDTH-1];
        end else begin
            So = sh_q[0];
        end
    end

    assign Po   = po_q;
    assign Busy = (state_q == SHIFT);
    assign Done = done_q;
    assign Err  = err_q;

    // Frame sequencing: shift while Load is high, commit or flag on Load drop.
    // On frame end the shadow is set to the resulting Po right away, so a frame
    // starting on the very next edge still reads back the committed value.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        po_d    = po_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (Load) begin
                    sh_d    = sh_shifted;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end else begin
                    sh_d  = po_q;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                if (Load) begin
                    sh_d = sh_shifted;
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (cnt_q == CNT_FULL) begin
                        po_d   = sh_q;
                        done_d = 1'b1;
                        err_d  = 1'b0;
                    end else begin
                        sh_d  = po_q;
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset to the default setting.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            sh_q    <= DEFAULT;
            po_q    <= DEFAULT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            po_q    <= po_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
